// File: rtl/strobe_log_arbiter_if.sv
// ---------------------------------------------------------------------------
// strobe_log_arbiter_if
//
// Purpose : Bundles the strobe inputs, the flush control, the single
//           valid/ready log-sink channel and the status outputs of
//           strobe_log_arbiter into one interface.
//
// Parameters
//   NREQ    number of strobe requesters (2..16)
//   DATA_W  record width
//   CNT_W   drop-counter width (present only with
//           STROBE_LOG_ARBITER_DROP_CNT_EN defined)
//
// Signals
//   stb_i        NREQ         per-requester one-cycle strobe
//   stb_data_i   NREQ*DATA_W  record of requester i at [i*DATA_W +: DATA_W]
//   flush_i      1            synchronous discard of everything pending
//   out_valid_o  1            output record valid
//   out_ready_i  1            sink accepts the output record
//   out_data_o   DATA_W       output record
//   out_src_o    SRC_W        requester index of the output record
//   pending_o    NREQ         FIFO i non-empty
//   drop_o       NREQ         one-cycle pulse: strobe of requester i dropped
//   drop_cnt_o   NREQ*CNT_W   saturating per-requester drop counts
//                             (STROBE_LOG_ARBITER_DROP_CNT_EN only)
//
// Modports
//   master : the requesters and the sink (drive strobes, flush and ready)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface strobe_log_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
  , parameter int CNT_W = 8
`endif
);

  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        stb_i;
  logic [NREQ*DATA_W-1:0] stb_data_i;
  logic                   flush_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [DATA_W-1:0]      out_data_o;
  logic [SRC_W-1:0]       out_src_o;
  logic [NREQ-1:0]        pending_o;
  logic [NREQ-1:0]        drop_o;
`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
  logic [NREQ*CNT_W-1:0]  drop_cnt_o;
`endif

  modport master (
    output stb_i, stb_data_i, flush_i, out_ready_i,
    input  out_valid_o, out_data_o, out_src_o, pending_o, drop_o
`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
    , input drop_cnt_o
`endif
  );

  modport slave (
    input  stb_i, stb_data_i, flush_i, out_ready_i,
    output out_valid_o, out_data_o, out_src_o, pending_o, drop_o
`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
    , output drop_cnt_o
`endif
  );

endinterface : strobe_log_arbiter_if

// File: rtl/strobe_log_arbiter.sv
// ---------------------------------------------------------------------------
// strobe_log_arbiter
//
// Purpose : Serialises fire-and-forget strobe records from NREQ requesters
//           onto one valid/ready log-sink channel. Every requester owns a
//           small FIFO; a round-robin arbiter pops the next non-empty FIFO
//           into a single output register whenever that register is free or
//           being accepted. A strobe that finds its FIFO full (and not being
//           popped in the same cycle) is dropped and reported on drop_o.
//
// Parameters
//   NREQ        number of requesters, 2..16
//   DATA_W      record width
//   FIFO_DEPTH  entries per requester FIFO, power of two, >= 2
//   CNT_W       drop-counter width (optional feature only)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    strobe_log_arbiter_if.slave: strobes, flush, sink channel,
//          pending/drop status (and drop_cnt_o with the optional feature)
//
// Optional feature
//   Define STROBE_LOG_ARBITER_DROP_CNT_EN to add drop_cnt_o: a per-requester
//   saturating count of drop_o pulses, cleared only by rst_n.
// ---------------------------------------------------------------------------
module strobe_log_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
  , parameter int CNT_W    = 8
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  strobe_log_arbiter_if.slave    bus
);

  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  // ------------------------------------------------------------------------
  // Declarations
  // ------------------------------------------------------------------------
  logic [NREQ-1:0]   w_empty;
  logic [NREQ-1:0]   w_full;
  logic [DATA_W-1:0] w_head [NREQ];

  logic [NREQ-1:0]   w_push;
  logic [NREQ-1:0]   w_pop;
  logic [NREQ-1:0]   w_drop;

  logic              w_load;
  logic              w_grant_vld;
  logic [SRC_W-1:0]  w_grant_idx;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SRC_W-1:0]  r_out_src;
  logic [SRC_W-1:0]  r_ptr;
  logic [NREQ-1:0]   r_drop;

  // Index k steps after p in the round-robin ring; modulo keeps it correct
  // for requester counts that are not a power of two.
  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] p,
                                              input int               k);
    int t;
    t = (int'(p) + k) % NREQ;
    return SRC_W'(t);
  endfunction

  // ------------------------------------------------------------------------
  // Arbitration: first non-empty FIFO scanning ptr+1, ptr+2, ... (wrapping)
  // ------------------------------------------------------------------------
  // The output register may take a new record when it is empty or its
  // current record is being accepted this cycle.
  assign w_load = !r_out_valid || bus.out_ready_i;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_grant_vld && !w_empty[rr_idx(r_ptr, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = rr_idx(r_ptr, k);
      end
    end
  end

  // Push/pop/drop qualification. Flush overrides everything: no pop, no
  // push and no drop report for strobes arriving in the flush cycle.
  always_comb begin
    w_pop  = '0;
    w_push = '0;
    w_drop = '0;
    if (!bus.flush_i && w_load && w_grant_vld) begin
      w_pop[w_grant_idx] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.flush_i && bus.stb_i[i]) begin
        // A full FIFO that is popped this cycle frees a slot for the push.
        if (!w_full[i] || w_pop[i]) begin
          w_push[i] = 1'b1;
        end else begin
          w_drop[i] = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Per-requester FIFOs (extra MSB on the pointers distinguishes full from
  // empty when the address bits match)
  // ------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_fifo
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;

    assign w_empty[gi] = (r_wptr == r_rptr);
    assign w_full[gi]  = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head[gi]  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else if (bus.flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[gi])  r_rptr <= r_rptr + 1'b1;
      end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers alone, so stale contents are never observed and the array
    // can map onto plain flops/RAM without a reset network.
    always_ff @(posedge clk) begin
      if (w_push[gi]) begin
        r_mem[r_wptr[AW-1:0]] <= bus.stb_data_i[gi*DATA_W +: DATA_W];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Output register, round-robin pointer and drop pulse
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= SRC_W'(NREQ - 1);   // requester 0 is scanned first
      r_drop      <= '0;
    end else begin
      r_drop <= w_drop;
      if (bus.flush_i) begin
        // Pointer deliberately kept so fairness continues across a flush.
        r_out_valid <= 1'b0;
      end else if (w_load) begin
        if (w_grant_vld) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_head[w_grant_idx];
          r_out_src   <= w_grant_idx;
          r_ptr       <= w_grant_idx;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef STROBE_LOG_ARBITER_DROP_CNT_EN
  // Saturating drop counters; only rst_n clears them, flush does not.
  for (genvar gc = 0; gc < NREQ; gc++) begin : g_drop_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (r_drop[gc] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign bus.drop_cnt_o[gc*CNT_W +: CNT_W] = r_cnt;
  end
`endif

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_src_o   = r_out_src;
  assign bus.pending_o   = ~w_empty;
  assign bus.drop_o      = r_drop;

endmodule : strobe_log_arbiter
